// File: rtl/imm_extend_pipe.sv
// Pipelined RISC-V immediate generator with a valid/ready output stage,
// a one-entry skid register, flush and a saturating illegal-format counter.
module imm_extend_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [24:0]      unextend_data,
   input  logic [2:0]       extend_func,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  extended_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [31:0]      imm32;
   logic [XLEN-1:0]  imm;
   logic             illegal;
   logic             sign;
   logic             accept;

   logic             skid_valid;
   logic [XLEN-1:0]  skid_data;
   logic [TAG_W-1:0] skid_tag;
   logic             skid_err;

   assign sign = unextend_data[24];

   // Every format fits a 32-bit value whose MSB is the correct fill bit, so a
   // single sign-extending cast widens it to XLEN (zero-extended formats have MSB 0).
   always_comb begin
      imm32   = '0;
      illegal = 1'b0;
      case (extend_func)
         3'd0: imm32 = {{20{sign}}, unextend_data[24:13]};
         3'd1: imm32 = {{20{sign}}, unextend_data[24:18], unextend_data[4:0]};
         3'd2: imm32 = {{20{sign}}, unextend_data[0], unextend_data[23:18],
                        unextend_data[4:1], 1'b0};
         3'd3: imm32 = {{12{sign}}, unextend_data[12:5], unextend_data[13],
                        unextend_data[23:14], 1'b0};
         3'd4: imm32 = {unextend_data[24:5], 12'b0};
         3'd5: imm32 = {27'b0, unextend_data[12:8]};
         3'd6: imm32 = (XLEN == 64) ? {26'b0, unextend_data[18:13]}
                                    : {27'b0, unextend_data[17:13]};
         default: illegal = 1'b1;
      endcase
   end

   assign imm      = XLEN'($signed(imm32));
   assign in_ready = !skid_valid;
   assign accept   = in_valid && in_ready && !flush;

   // Output stage plus skid: the skid only fills when a beat arrives while the
   // output is stalled, and always drains into the output before new beats.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid     <= 1'b0;
         extended_data <= '0;
         out_tag       <= '0;
         out_err       <= 1'b0;
         skid_valid    <= 1'b0;
         skid_data     <= '0;
         skid_tag      <= '0;
         skid_err      <= 1'b0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (skid_valid) begin
         if (out_ready) begin
            extended_data <= skid_data;
            out_tag       <= skid_tag;
            out_err       <= skid_err;
            skid_valid    <= 1'b0;
         end
      end else if (accept) begin
         if (!out_valid || out_ready) begin
            out_valid     <= 1'b1;
            extended_data <= illegal ? '0 : imm;
            out_tag       <= in_tag;
            out_err       <= illegal;
         end else begin
            skid_valid <= 1'b1;
            skid_data  <= illegal ? '0 : imm;
            skid_tag   <= in_tag;
            skid_err   <= illegal;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Counts accepted illegal beats; flush does not touch it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_cnt <= '0;
      end else if (accept && illegal && (err_cnt != CNT_MAX)) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: XLEN=32 and XLEN=64 instances share one stimulus
// stream and are checked against a queue of expected beats built from full instructions.
module tb_imm_extend_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [24:0] unextend_data = '0;
   logic [2:0]  extend_func = '0;
   logic [31:0] in_tag = '0;
   logic        out_ready = 1'b1;

   logic        in_ready, out_valid, out_err;
   logic [31:0] extended_data, out_tag;
   logic [7:0]  err_cnt;
   logic        in_ready64, out_valid64, out_err64;
   logic [63:0] extended_data64;
   logic [31:0] out_tag64;
   logic [7:0]  err_cnt64;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] tag;
      logic [63:0] d32;
      logic [63:0] d64;
      logic        err;
   } exp_t;
   exp_t sb[$];
   int   exp_cnt = 0;

   imm_extend_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .unextend_data(unextend_data), .extend_func(extend_func), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .extended_data(extended_data),
      .out_tag(out_tag), .out_err(out_err), .err_cnt(err_cnt));

   imm_extend_pipe #(.XLEN(64), .TAG_W(32), .CNT_W(8)) dut64 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
      .unextend_data(unextend_data), .extend_func(extend_func), .in_tag(in_tag),
      .out_valid(out_valid64), .out_ready(out_ready), .extended_data(extended_data64),
      .out_tag(out_tag64), .out_err(out_err64), .err_cnt(err_cnt64));

   always #5 clk = ~clk;

   // Reference immediate built from the architectural instruction fields.
   function automatic logic [63:0] model_imm(input logic [31:0] ins, input logic [2:0] f,
                                             input bit x64);
      logic [63:0] r;
      case (f)
         3'd0: r = {{52{ins[31]}}, ins[31:20]};
         3'd1: r = {{52{ins[31]}}, ins[31:25], ins[11:7]};
         3'd2: r = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         3'd3: r = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         3'd4: r = {{32{ins[31]}}, ins[31:12], 12'b0};
         3'd5: r = {59'b0, ins[19:15]};
         3'd6: r = x64 ? {58'b0, ins[25:20]} : {59'b0, ins[24:20]};
         default: r = '0;
      endcase
      if (!x64) r = {32'b0, r[31:0]};
      return r;
   endfunction

   task automatic check_output(input string name, input logic [63:0] got,
                               input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [31:0] ins, input logic [2:0] f,
                                 input logic [31:0] tag);
      in_valid      = 1'b1;
      unextend_data = ins[31:7];
      extend_func   = f;
      in_tag        = tag;
   endtask

   task automatic send_check(input string name, input logic [31:0] ins, input logic [2:0] f,
                             input logic [31:0] tag, input logic [63:0] e32,
                             input logic [63:0] e64);
      out_ready = 1'b1;
      apply_stimulus(ins, f, tag);
      tick();
      in_valid = 1'b0;
      check_output({name, "_valid"}, out_valid, 1);
      check_output({name, "_d32"}, extended_data, e32);
      check_output({name, "_d64"}, extended_data64, e64);
      check_output({name, "_err"}, out_err, 0);
   endtask

   initial begin
      // Monitor: compares each delivered beat and the error counter mid-cycle,
      // then records what the coming edge will accept.
      fork
         forever begin
            exp_t e;
            logic [31:0] ins;
            @(negedge clk);
            if (!rst) begin
               sb.delete();
               exp_cnt = 0;
            end else begin
               check_output("err_cnt", err_cnt, exp_cnt);
               check_output("err_cnt64", err_cnt64, exp_cnt);
               if (out_valid && out_ready) begin
                  check_output("beat_expected", 64'(sb.size() > 0), 1);
                  if (sb.size() > 0) begin
                     e = sb.pop_front();
                     check_output("tag", out_tag, e.tag);
                     check_output("data32", extended_data, e.d32);
                     check_output("err", out_err, e.err);
                     check_output("valid64", out_valid64, 1);
                     check_output("tag64", out_tag64, e.tag);
                     check_output("data64", extended_data64, e.d64);
                     check_output("err64", out_err64, e.err);
                  end
               end
               if (flush) begin
                  sb.delete();
               end else if (in_valid && in_ready) begin
                  ins   = {unextend_data, 7'b0};
                  e.tag = in_tag;
                  e.d32 = model_imm(ins, extend_func, 1'b0);
                  e.d64 = model_imm(ins, extend_func, 1'b1);
                  e.err = (extend_func == 3'd7);
                  sb.push_back(e);
                  if (e.err && exp_cnt < 255) exp_cnt++;
               end
            end
         end
      join_none

      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_output("rst_valid", out_valid, 0);
      check_output("rst_data", extended_data, 0);
      check_output("rst_tag", out_tag, 0);
      check_output("rst_err", out_err, 0);
      check_output("rst_cnt", err_cnt, 0);
      rst = 1'b1;
      tick();
      check_output("rst_ready", in_ready, 1);

      // Directed formats with hand-computed immediates
      send_check("addi_m1", 32'hFFF00093, 3'd0, 32'h100, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
      send_check("beq_m4", 32'hFE000EE3, 3'd2, 32'h104, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
      send_check("lui", 32'h123450B7, 3'd4, 32'h108, 64'h12345000, 64'h0000000012345000);
      send_check("lui_neg", 32'h800000B7, 3'd4, 32'h10C, 64'h80000000, 64'hFFFFFFFF80000000);
      send_check("csr_z", 32'h340FD073, 3'd5, 32'h110, 64'h1F, 64'h1F);
      send_check("slli63", 32'h03F09093, 3'd6, 32'h114, 64'h1F, 64'h3F);
      send_check("sw_m8", 32'hFE112C23, 3'd1, 32'h118, 64'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8);
      send_check("jal_m8", 32'hFF9FF0EF, 3'd3, 32'h11C, 64'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8);
      tick();
      check_output("idle_valid", out_valid, 0);

      // Back-pressure: tag 1 in output, tag 2 in skid, tag 3 held upstream
      out_ready = 1'b0;
      apply_stimulus(32'h00100093, 3'd0, 32'd1);
      tick();
      in_tag = 32'd2;
      tick();
      check_output("bp_ready", in_ready, 0);
      check_output("bp_ready64", in_ready64, 0);
      check_output("bp_tag1", out_tag, 1);
      in_tag = 32'd3;
      tick();
      check_output("bp_hold_tag", out_tag, 1);
      check_output("bp_hold_valid", out_valid, 1);
      out_ready = 1'b1;
      tick();
      check_output("bp_tag2", out_tag, 2);
      check_output("bp_ready_again", in_ready, 1);
      tick();
      check_output("bp_tag3", out_tag, 3);
      in_valid = 1'b0;
      tick();
      check_output("bp_drained", out_valid, 0);

      // Flush with both entries full and a beat waiting, then a flush with room
      out_ready = 1'b0;
      apply_stimulus(32'h00A00093, 3'd0, 32'd10);
      tick();
      in_tag = 32'd11;
      tick();
      in_tag = 32'd12;
      check_output("fl_full", in_ready, 0);
      flush = 1'b1;
      tick();
      check_output("fl_valid", out_valid, 0);
      check_output("fl_ready", in_ready, 1);
      in_tag = 32'd13;
      tick();
      check_output("fl_discard", out_valid, 0);
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick();
      check_output("fl_nothing", out_valid, 0);

      // Random mixed traffic with random back-pressure
      for (int i = 0; i < 60; i++) begin
         in_valid      = 1'($urandom_range(0, 1));
         unextend_data = 25'($urandom);
         extend_func   = 3'($urandom_range(0, 7));
         in_tag        = 32'(1000 + i);
         out_ready     = 1'($urandom_range(0, 3) != 0);
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick();
      check_output("rnd_drained", 64'(sb.size()), 0);

      // Illegal beats: counter saturates and flush leaves it alone
      for (int i = 0; i < 300; i++) begin
         apply_stimulus(32'($urandom), 3'd7, 32'(5000 + i));
         tick();
      end
      in_valid = 1'b0;
      tick();
      check_output("sat_cnt", err_cnt, 255);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      check_output("sat_after_flush", err_cnt, 255);

      // Asynchronous reset between edges with both entries holding illegal beats
      out_ready = 1'b0;
      apply_stimulus(32'h0, 3'd7, 32'd77);
      repeat (2) tick();
      check_output("pre_rst_err", out_err, 1);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check_output("arst_valid", out_valid, 0);
      check_output("arst_err", out_err, 0);
      check_output("arst_cnt", err_cnt, 0);
      check_output("arst_data", extended_data, 0);
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check_output("post_rst_ready", in_ready, 1);
      check_output("post_rst_valid", out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
